// File: rtl/binary_mul_acc_16_pkg.sv
// Shared definitions for the 16x16 multiplier family: widths and the
// accumulation-stage state encoding.
package binary_mul_acc_16_pkg;

    localparam int unsigned OP_W      = 16;
    localparam int unsigned PROD_W    = 2 * OP_W;
    localparam int unsigned ACC_W_DEF = 40;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/binary_acc_reg.sv
// One-entry result register: holds a finished group total until popped.
// A load in the same cycle as a pop wins, so back-to-back groups stream.
module binary_acc_reg
    import binary_mul_acc_16_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_pop,
    input  logic [ACC_W-1:0] i_acc,
    input  logic             i_ovf,
    input  logic [CNT_W-1:0] i_cnt,
    output logic             o_valid,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_cnt
);

    logic             r_valid;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_acc   <= i_acc;
            r_ovf   <= i_ovf;
            r_cnt   <= i_cnt;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_acc   = r_acc;
    assign o_ovf   = r_ovf;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/binary_mul_acc_16.sv
// Accumulation stage behind the 16x16 multiplier: sums product groups into a
// wide accumulator and hands each total to a one-entry valid/ready register.
module binary_mul_acc_16
    import binary_mul_acc_16_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,   // must be >= PROD_W
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [PROD_W-1:0] P_in,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  ACC,
    output logic              ovf,
    output logic [CNT_W-1:0]  count
);

    acc_state_e       r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    logic             w_hold;
    logic             w_accept;
    logic             w_pop;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic [CNT_W-1:0] w_cnt;

    // Backpressure only while a finished total is waiting and not being taken.
    assign w_hold   = (r_state == ST_HOLD);
    assign in_ready = en && (!w_hold || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_pop    = en && w_hold && out_ready;

    assign w_sum = {1'b0, r_acc} + (ACC_W+1)'(P_in);
    assign w_ovf = r_ovf | w_sum[ACC_W];
    assign w_cnt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Closing a group clears the running sum on the same edge the result loads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            if (in_last) begin
                r_state <= ST_HOLD;
                r_acc   <= '0;
                r_ovf   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_state <= ST_ACCUM;
                r_acc   <= w_sum[ACC_W-1:0];
                r_ovf   <= w_ovf;
                r_cnt   <= w_cnt;
            end
        end else if (w_pop) begin
            r_state <= ST_IDLE;
        end
    end

    binary_acc_reg #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_acc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_accept && in_last),
        .i_pop   (w_pop),
        .i_acc   (w_sum[ACC_W-1:0]),
        .i_ovf   (w_ovf),
        .i_cnt   (w_cnt),
        .o_valid (out_valid),
        .o_acc   (ACC),
        .o_ovf   (ovf),
        .o_cnt   (count)
    );

endmodule

// File: tb/tb_binary_mul_acc_16.sv
// Bench for binary_mul_acc_16: a default-width instance and an ACC_W=32,
// CNT_W=2 instance share stimulus and are checked against a group-sum model.
module tb_binary_mul_acc_16;

    logic        clk = 1'b0;
    logic        rst_n, en, in_valid, in_last, out_ready;
    logic [31:0] P_in;

    logic        rdy_a, vld_a, ovf_a;
    logic [39:0] acc_a;
    logic [15:0] cnt_a;
    logic        rdy_b, vld_b, ovf_b;
    logic [31:0] acc_b;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    binary_mul_acc_16 dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_last(in_last),
        .P_in(P_in), .in_ready(rdy_a), .out_valid(vld_a), .out_ready(out_ready),
        .ACC(acc_a), .ovf(ovf_a), .count(cnt_a)
    );

    binary_mul_acc_16 #(.ACC_W(32), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .in_valid(in_valid), .in_last(in_last),
        .P_in(P_in), .in_ready(rdy_b), .out_valid(vld_b), .out_ready(out_ready),
        .ACC(acc_b), .ovf(ovf_b), .count(cnt_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: true (unbounded) group sum and beat count; the held
    // result is derived from them per instance width.
    bit              m_valid;
    longint unsigned g_sum;
    int              g_n;
    logic [39:0]     e_acc_a;
    bit              e_ovf_a;
    logic [15:0]     e_cnt_a;
    logic [31:0]     e_acc_b;
    bit              e_ovf_b;
    logic [1:0]      e_cnt_b;
    bit              exp_ready, obs_rdy_a, obs_rdy_b;

    task automatic close_group();
        e_acc_a = 40'(g_sum);
        e_ovf_a = (g_sum >> 40) != 0;
        e_cnt_a = (g_n > 65535) ? 16'hFFFF : 16'(g_n);
        e_acc_b = 32'(g_sum);
        e_ovf_b = (g_sum >> 32) != 0;
        e_cnt_b = (g_n > 3) ? 2'd3 : 2'(g_n);
        g_sum   = 0;
        g_n     = 0;
        m_valid = 1'b1;
    endtask

    // One clock of stimulus; samples in_ready before the edge, updates model after.
    task automatic drive(input bit e, input bit v, input bit l, input logic [31:0] p, input bit r);
        bit acc_beat;
        en = e; in_valid = v; in_last = l; P_in = p; out_ready = r;
        #1;
        exp_ready = e && (!m_valid || r);
        acc_beat  = e && v && exp_ready;
        obs_rdy_a = rdy_a;
        obs_rdy_b = rdy_b;
        @(posedge clk);
        #1;
        if (e && m_valid && r) m_valid = 1'b0;
        if (acc_beat) begin
            g_sum += 64'(p);
            g_n++;
            if (l) close_group();
        end
    endtask

    task automatic do_reset(input bit v, input logic [31:0] p);
        rst_n = 1'b0; en = 1'b1; in_valid = v; in_last = 1'b1; P_in = p; out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_valid = 1'b0;
        g_sum   = 0;
        g_n     = 0;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 32'd123, 0);
        do_reset(1, 32'd7);
        n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b exp 0", vld_a); end
        n_cmp++; if (acc_a !== 40'd0) begin n_err++; $display("FAIL reset_acc: got %0d exp 0", acc_a); end
        n_cmp++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b exp 0", ovf_a); end
        n_cmp++; if (cnt_a !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d exp 0", cnt_a); end
        n_cmp++; if (acc_b !== 32'd0) begin n_err++; $display("FAIL reset_acc_b: got %0d exp 0", acc_b); end
        en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_cmp++; if (rdy_a !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b exp 1", rdy_a); end
    endtask

    task automatic test_basic_group();
        drive(1, 1, 0, 32'd6, 1);
        drive(1, 1, 0, 32'd7, 1);
        n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL basic_mid_valid: got %0b exp 0", vld_a); end
        drive(1, 1, 1, 32'd8, 1);
        n_cmp++; if (vld_a !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %0b exp 1", vld_a); end
        n_cmp++; if (acc_a !== 40'd21) begin n_err++; $display("FAIL basic_acc: got %0d exp 21", acc_a); end
        n_cmp++; if (cnt_a !== 16'd3) begin n_err++; $display("FAIL basic_count: got %0d exp 3", cnt_a); end
        n_cmp++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL basic_ovf: got %0b exp 0", ovf_a); end
        drive(1, 0, 0, 32'd0, 1);
        n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL basic_pop: got %0b exp 0", vld_a); end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 1, 32'd65025, 1);
        n_cmp++; if (acc_a !== 40'd65025) begin n_err++; $display("FAIL b2b_acc0: got %0d exp 65025", acc_a); end
        n_cmp++; if (cnt_a !== 16'd1) begin n_err++; $display("FAIL b2b_cnt0: got %0d exp 1", cnt_a); end
        drive(1, 1, 1, 32'd4294836225, 1);
        n_cmp++; if (obs_rdy_a !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %0b exp 1", obs_rdy_a); end
        n_cmp++; if (vld_a !== 1'b1) begin n_err++; $display("FAIL b2b_valid1: got %0b exp 1", vld_a); end
        n_cmp++; if (acc_a !== 40'd4294836225) begin n_err++; $display("FAIL b2b_acc1: got %0d exp 4294836225", acc_a); end
        n_cmp++; if (cnt_a !== 16'd1) begin n_err++; $display("FAIL b2b_cnt1: got %0d exp 1", cnt_a); end
        drive(1, 0, 0, 32'd0, 1);
    endtask

    task automatic test_overflow();
        drive(1, 1, 0, 32'hFFFF_FFFF, 1);
        drive(1, 1, 1, 32'd2, 1);
        n_cmp++; if (acc_b !== 32'd1) begin n_err++; $display("FAIL ovf_acc32: got %0d exp 1", acc_b); end
        n_cmp++; if (ovf_b !== 1'b1) begin n_err++; $display("FAIL ovf_flag32: got %0b exp 1", ovf_b); end
        n_cmp++; if (cnt_b !== 2'd2) begin n_err++; $display("FAIL ovf_cnt32: got %0d exp 2", cnt_b); end
        n_cmp++; if (acc_a !== 40'h01_0000_0001) begin n_err++; $display("FAIL ovf_acc40: got %0h exp 100000001", acc_a); end
        n_cmp++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL ovf_flag40: got %0b exp 0", ovf_a); end
        drive(1, 1, 1, 32'd5, 1);
        n_cmp++; if (ovf_b !== 1'b0) begin n_err++; $display("FAIL ovf_cleared: got %0b exp 0", ovf_b); end
        n_cmp++; if (acc_b !== 32'd5) begin n_err++; $display("FAIL ovf_next_acc: got %0d exp 5", acc_b); end
        drive(1, 0, 0, 32'd0, 1);
    endtask

    task automatic test_backpressure();
        drive(1, 1, 1, 32'd4, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 32'd1, 0);
            n_cmp++; if (obs_rdy_a !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %0b exp 0", i, obs_rdy_a); end
            n_cmp++; if (acc_a !== 40'd4 || vld_a !== 1'b1) begin
                n_err++; $display("FAIL bp_hold[%0d]: got acc %0d valid %0b exp acc 4 valid 1", i, acc_a, vld_a);
            end
        end
        drive(1, 1, 0, 32'd9, 1);
        n_cmp++; if (obs_rdy_a !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b exp 1", obs_rdy_a); end
        n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL bp_release_pop: got %0b exp 0", vld_a); end
        drive(1, 1, 1, 32'd1, 1);
        n_cmp++; if (acc_a !== 40'd10) begin n_err++; $display("FAIL bp_next_acc: got %0d exp 10", acc_a); end
        n_cmp++; if (cnt_a !== 16'd2) begin n_err++; $display("FAIL bp_next_cnt: got %0d exp 2", cnt_a); end
        drive(1, 0, 0, 32'd0, 1);
    endtask

    task automatic test_enable();
        drive(1, 1, 0, 32'd10, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 32'd100, 1);
            n_cmp++; if (obs_rdy_a !== 1'b0) begin n_err++; $display("FAIL en_ready[%0d]: got %0b exp 0", i, obs_rdy_a); end
        end
        drive(1, 1, 1, 32'd20, 0);
        n_cmp++; if (acc_a !== 40'd30) begin n_err++; $display("FAIL en_acc: got %0d exp 30", acc_a); end
        n_cmp++; if (cnt_a !== 16'd2) begin n_err++; $display("FAIL en_cnt: got %0d exp 2", cnt_a); end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 32'd55, 1);
            n_cmp++; if (vld_a !== 1'b1 || acc_a !== 40'd30) begin
                n_err++; $display("FAIL en_hold[%0d]: got valid %0b acc %0d exp valid 1 acc 30", i, vld_a, acc_a);
            end
        end
        drive(1, 0, 0, 32'd0, 1);
        n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL en_pop: got %0b exp 0", vld_a); end
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 0, 32'd5, 1);
        drive(1, 1, 0, 32'd6, 1);
        do_reset(1, 32'd7);
        n_cmp++; if (vld_a !== 1'b0 || acc_a !== 40'd0 || cnt_a !== 16'd0) begin
            n_err++; $display("FAIL rstmid_clear: got valid %0b acc %0d cnt %0d exp 0 0 0", vld_a, acc_a, cnt_a);
        end
        drive(1, 1, 1, 32'd3, 0);
        n_cmp++; if (acc_a !== 40'd3 || cnt_a !== 16'd1) begin
            n_err++; $display("FAIL rstmid_fresh: got acc %0d cnt %0d exp 3 1", acc_a, cnt_a);
        end
        do_reset(0, 32'd0);
        n_cmp++; if (vld_a !== 1'b0 || acc_a !== 40'd0) begin
            n_err++; $display("FAIL rsthold_clear: got valid %0b acc %0d exp 0 0", vld_a, acc_a);
        end
        drive(1, 1, 1, 32'd3, 1);
        n_cmp++; if (acc_a !== 40'd3) begin n_err++; $display("FAIL rsthold_fresh: got %0d exp 3", acc_a); end
        drive(1, 0, 0, 32'd0, 1);
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 5; i++) drive(1, 1, (i == 4), 32'd1, 1);
        n_cmp++; if (cnt_b !== 2'd3) begin n_err++; $display("FAIL sat_cnt_b: got %0d exp 3", cnt_b); end
        n_cmp++; if (cnt_a !== 16'd5) begin n_err++; $display("FAIL sat_cnt_a: got %0d exp 5", cnt_a); end
        n_cmp++; if (acc_b !== 32'd5) begin n_err++; $display("FAIL sat_acc_b: got %0d exp 5", acc_b); end
        drive(1, 0, 0, 32'd0, 1);
    endtask

    task automatic test_random();
        bit          e, v, l, r;
        logic [31:0] p;
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) != 0);
            p = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 15))) : 32'($urandom);
            drive(e, v, l, p, r);
            n_cmp++; if (obs_rdy_a !== exp_ready || obs_rdy_b !== exp_ready) begin
                n_err++; $display("FAIL rnd_ready[%0d]: got %0b/%0b exp %0b", i, obs_rdy_a, obs_rdy_b, exp_ready);
            end
            n_cmp++; if (vld_a !== m_valid || vld_b !== m_valid) begin
                n_err++; $display("FAIL rnd_valid[%0d]: got %0b/%0b exp %0b", i, vld_a, vld_b, m_valid);
            end
            if (m_valid) begin
                n_cmp++; if (acc_a !== e_acc_a || ovf_a !== e_ovf_a || cnt_a !== e_cnt_a) begin
                    n_err++; $display("FAIL rnd_result_a[%0d]: got %0h/%0b/%0d exp %0h/%0b/%0d",
                                      i, acc_a, ovf_a, cnt_a, e_acc_a, e_ovf_a, e_cnt_a);
                end
                n_cmp++; if (acc_b !== e_acc_b || ovf_b !== e_ovf_b || cnt_b !== e_cnt_b) begin
                    n_err++; $display("FAIL rnd_result_b[%0d]: got %0h/%0b/%0d exp %0h/%0b/%0d",
                                      i, acc_b, ovf_b, cnt_b, e_acc_b, e_ovf_b, e_cnt_b);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_last = 1'b0; P_in = '0; out_ready = 1'b0;
        m_valid = 1'b0; g_sum = 0; g_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_basic_group();
        test_back_to_back();
        test_overflow();
        test_backpressure();
        test_enable();
        test_reset_mid();
        test_count_sat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/binary_mul_acc_16.md
# binary_mul_acc_16

Downstream accumulation stage for the 16x16 unsigned multiplier, whose P output is registered with one-cycle latency. It sums a group of 32-bit products into a wide accumulator and presents each group total through a one-entry output register with a valid/ready handshake. Input backpressure is applied only while a finished total is waiting. A sticky overflow flag and a product count travel with each result.

## Interface
- ACC_W, 40, accumulator and result width; must be at least 32.
- CNT_W, 16, width of the product counter.

- clk  in  1  single clock; everything is registered on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  global enable; when low, all state freezes.
- in_valid  in  1  P_in carries a product.
- in_last  in  1  marks the final product of a group.
- P_in  in  32  unsigned product from the multiplier.
- in_ready  out  1  stage accepts a beat this cycle.
- out_valid  out  1  ACC, ovf and count are valid.
- out_ready  in  1  consumer takes the result.
- ACC  out  ACC_W  group sum, modulo 2^ACC_W.
- ovf  out  1  a carry out of ACC_W occurred within the group.
- count  out  CNT_W  number of products in the group, saturating.

## Operation
- Accept condition: en && in_valid && in_ready.
- in_ready = en && (!out_valid || out_ready).
- Internal state:
  - acc_r (ACC_W bits), ovf_r, cnt_r.
  - Result register: ACC, ovf, count, out_valid.
- Accumulate: on every accepted beat, P_in is zero-extended and added to acc_r.
  - The carry out of bit ACC_W-1 is ORed into ovf_r.
  - cnt_r increments and saturates at 2^CNT_W-1.
- Group close: an accepted beat with in_last=1 loads the result register with the updated sum, ovf and count, including that beat.
  - The same edge clears acc_r, ovf_r and cnt_r to 0.
  - out_valid is set to 1.
- A group of one beat is legal; its result is ACC = P_in and count = 1.
- FSM states:
  - IDLE: acc empty, out_valid=0.
  - ACCUM: at least one beat accumulated, out_valid=0.
  - HOLD: out_valid=1.
- FSM transitions:
  - IDLE→ACCUM on an accepted non-last beat.
  - IDLE/ACCUM→HOLD on an accepted last beat.
  - HOLD→IDLE on out_ready with no accept.
  - HOLD→ACCUM on out_ready with an accepted non-last beat in the same cycle.
  - HOLD→HOLD on out_ready with an accepted last beat (the result register is reloaded in the same cycle).
- A beat is accepted in HOLD only when out_ready=1 in the same cycle.
- en=0: no beat is accepted and no result is popped. All registers hold their values; outputs stay stable.
- A new group's partial sum never disturbs a held result.

## Timing
- Reset, applied on a rising edge with rst_n=0, produces:
  - out_valid=0, ACC=0, ovf=0, count=0.
  - acc_r, ovf_r and cnt_r cleared; FSM in IDLE.
  - in_ready=1 on the following cycle if en=1.
- Reset mid-group or during HOLD discards all partial and held data.
- Latency: the result is visible (out_valid=1) in the cycle after the edge that accepted the last beat.
- Throughput: one beat per cycle while out_ready is held at 1. Back-to-back single-beat groups produce one result per cycle.
- in_ready is combinational from out_valid, out_ready and en. No other output is combinational from inputs.
- ACC, ovf and count hold stable while out_valid=1 and out_ready=0.
- in_last without in_valid is ignored.

## Structure
- The shared package for the multiplier family holds:
  - Constants: operand width 16, product width 32, default ACC_W and CNT_W.
  - The FSM state enum {IDLE, ACCUM, HOLD}.
- Sub-module binary_acc_reg: the one-entry result register with its valid/ready handshake.
- Accumulation datapath and FSM live in the top.

## Test plan
- Reset then group {6, 7, 8} with last on 8, out_ready=1 → one cycle after the last beat: out_valid=1, ACC=21, count=3, ovf=0.
- Single-beat groups 65025 then 4294836225 back-to-back, out_ready=1 → consecutive results 65025 and 4294836225, each with count=1.
- With ACC_W=32: group {0xFFFFFFFF, 2} → ACC=1, ovf=1, count=2. The following group {5} → ovf=0.
- Result held with out_ready=0 for 4 cycles → in_ready=0 and ACC stable. Raising out_ready together with a valid beat of 9 → beat accepted and next group starts at acc 9.
- en=0 for 3 cycles mid-group while in_valid=1 → no accept and state frozen. The final sum matches the sum of beats accepted while en was high.
- rst_n low for one edge during a group → out_valid=0, ACC=0, count=0. A fresh group {3} then gives ACC=3.
